// File: rtl/fcr_uart_bridge_pkg.sv
// Shared types and constants for the host UART <-> command-response controller bridge.
// Holds the FSM state encodings and the baud divisor calculation.
package fcr_uart_bridge_pkg;

   localparam int C_FRAME_BYTES = 17;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
   typedef enum logic [1:0] {C_IDLE, C_REQ, C_WAIT} cmd_state_e;
   typedef enum logic [0:0] {R_IDLE, R_ACK} rsp_state_e;

   // Clock cycles per UART bit, rounded to nearest.
   function automatic int calc_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/fcr_uart_bridge_byte_fifo.sv
// Synchronous byte FIFO with show-ahead head output; a pop frees its slot for a
// push in the same cycle, so push+pop while full is accepted.
module fcr_uart_bridge_byte_fifo #(
   parameter int AW = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push_i,
   input  logic [7:0] din_i,
   input  logic       pop_i,
   output logic [7:0] dout_o,
   output logic       full_o,
   output logic       empty_o
);

   logic [7:0]  mem_q [2**AW];
   logic [AW:0] wr_q;
   logic [AW:0] rd_q;
   logic        do_push;
   logic        do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign dout_o  = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
   end

endmodule

// File: rtl/fcr_uart_bridge.sv
// 8N1 UART receiver/transmitter bridged onto the controller's 4-phase
// command-byte and response-byte handshakes, with a byte FIFO on the RX side.
module fcr_uart_bridge
   import fcr_uart_bridge_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int RX_FIFO_AW = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic       uart_tx,
   output logic       cmd_byte_req,
   output logic [7:0] cmd_byte_data,
   input  logic       cmd_byte_ack,
   input  logic       rsp_byte_req,
   input  logic [7:0] rsp_byte_data,
   output logic       rsp_byte_ack,
   output logic       rx_overrun,
   output logic       rx_frame_err
);

   localparam int             DIV     = calc_div(CLK_HZ, BAUD);
   localparam int             CW      = $clog2(DIV + 1);
   localparam logic [CW-1:0]  DIV_M1  = CW'(DIV - 1);
   localparam logic [CW-1:0]  HALF_M1 = CW'(DIV / 2 - 1);

   logic [1:0] rx_sync_q, ack_sync_q, req_sync_q;
   logic       rx_prev_q;
   logic       rx_s, ack_s, req_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_sync_q  <= 2'b11;
         ack_sync_q <= 2'b00;
         req_sync_q <= 2'b00;
         rx_prev_q  <= 1'b1;
      end else begin
         rx_sync_q  <= {rx_sync_q[0], uart_rx};
         ack_sync_q <= {ack_sync_q[0], cmd_byte_ack};
         req_sync_q <= {req_sync_q[0], rsp_byte_req};
         rx_prev_q  <= rx_sync_q[1];
      end
   end

   assign rx_s  = rx_sync_q[1];
   assign ack_s = ack_sync_q[1];
   assign req_s = req_sync_q[1];

   rx_state_e     rx_state_q;
   logic [CW-1:0] rx_cnt_q;
   logic [2:0]    rx_bit_q;
   logic [7:0]    rx_shift_q;
   logic          rx_push_q;
   logic          rx_frame_err_q;
   logic          rx_overrun_q;
   logic          fifo_full, fifo_empty, fifo_pop;
   logic [7:0]    fifo_dout;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_q     <= RX_IDLE;
         rx_cnt_q       <= '0;
         rx_bit_q       <= '0;
         rx_shift_q     <= '0;
         rx_push_q      <= 1'b0;
         rx_frame_err_q <= 1'b0;
      end else begin
         rx_push_q <= 1'b0;
         case (rx_state_q)
            RX_IDLE: if (rx_prev_q && !rx_s) begin
               rx_cnt_q   <= '0;
               rx_state_q <= RX_START;
            end
            RX_START: if (rx_cnt_q == HALF_M1) begin
               rx_cnt_q   <= '0;
               rx_bit_q   <= '0;
               rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
            end else rx_cnt_q <= rx_cnt_q + 1'b1;
            RX_DATA: if (rx_cnt_q == DIV_M1) begin
               rx_cnt_q   <= '0;
               rx_shift_q <= {rx_s, rx_shift_q[7:1]};
               rx_bit_q   <= rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            end else rx_cnt_q <= rx_cnt_q + 1'b1;
            RX_STOP: if (rx_cnt_q == DIV_M1) begin
               rx_cnt_q   <= '0;
               rx_state_q <= RX_IDLE;
               if (rx_s) rx_push_q      <= 1'b1;
               else      rx_frame_err_q <= 1'b1;
            end else rx_cnt_q <= rx_cnt_q + 1'b1;
            default: rx_state_q <= RX_IDLE;
         endcase
      end
   end

   // A full FIFO still accepts the byte when the command side pops in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     rx_overrun_q <= 1'b0;
      else if (rx_push_q && fifo_full && !fifo_pop)   rx_overrun_q <= 1'b1;
   end

   fcr_uart_bridge_byte_fifo #(.AW(RX_FIFO_AW)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (rx_push_q),
      .din_i   (rx_shift_q),
      .pop_i   (fifo_pop),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // 4-phase handshakes: req rises with data stable, ack rises, req falls, ack falls;
   // a new req may only rise after ack has been seen low again.
   cmd_state_e cmd_state_q;
   logic       cmd_req_q;
   logic [7:0] cmd_data_q;

   assign fifo_pop = (cmd_state_q == C_IDLE) && !fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_state_q <= C_IDLE;
         cmd_req_q   <= 1'b0;
         cmd_data_q  <= '0;
      end else begin
         case (cmd_state_q)
            C_IDLE: if (!fifo_empty) begin
               cmd_data_q  <= fifo_dout;
               cmd_req_q   <= 1'b1;
               cmd_state_q <= C_REQ;
            end
            C_REQ: if (ack_s) begin
               cmd_req_q   <= 1'b0;
               cmd_state_q <= C_WAIT;
            end
            C_WAIT: if (!ack_s) cmd_state_q <= C_IDLE;
            default: cmd_state_q <= C_IDLE;
         endcase
      end
   end

   rsp_state_e    rsp_state_q;
   logic          rsp_ack_q;
   logic          tx_busy_q;
   logic [9:0]    tx_shift_q;
   logic [CW-1:0] tx_cnt_q;
   logic [3:0]    tx_bit_q;
   logic          uart_tx_q;

   // The ack and the TX load share one edge; the start bit appears on the next one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_state_q <= R_IDLE;
         rsp_ack_q   <= 1'b0;
         tx_busy_q   <= 1'b0;
         tx_shift_q  <= '1;
         tx_cnt_q    <= '0;
         tx_bit_q    <= '0;
         uart_tx_q   <= 1'b1;
      end else begin
         case (rsp_state_q)
            R_IDLE: if (req_s && !tx_busy_q) begin
               tx_shift_q  <= {1'b1, rsp_byte_data, 1'b0};
               tx_busy_q   <= 1'b1;
               tx_cnt_q    <= '0;
               tx_bit_q    <= '0;
               rsp_ack_q   <= 1'b1;
               rsp_state_q <= R_ACK;
            end
            R_ACK: if (!req_s) begin
               rsp_ack_q   <= 1'b0;
               rsp_state_q <= R_IDLE;
            end
            default: rsp_state_q <= R_IDLE;
         endcase
         if (tx_busy_q) begin
            if (tx_cnt_q == '0) begin
               uart_tx_q  <= tx_shift_q[0];
               tx_shift_q <= {1'b1, tx_shift_q[9:1]};
            end
            if (tx_cnt_q == DIV_M1) begin
               tx_cnt_q <= '0;
               if (tx_bit_q == 4'd9) tx_busy_q <= 1'b0;
               else                  tx_bit_q  <= tx_bit_q + 4'd1;
            end else tx_cnt_q <= tx_cnt_q + 1'b1;
         end
      end
   end

   assign uart_tx       = uart_tx_q;
   assign cmd_byte_req  = cmd_req_q;
   assign cmd_byte_data = cmd_data_q;
   assign rsp_byte_ack  = rsp_ack_q;
   assign rx_overrun    = rx_overrun_q;
   assign rx_frame_err  = rx_frame_err_q;

endmodule

// File: tb/tb_fcr_uart_bridge.sv
// Directed bench for fcr_uart_bridge, run with a small bit divisor (DIV = 8).
module tb_fcr_uart_bridge;
   import fcr_uart_bridge_pkg::*;

   localparam int CLK_HZ = 1_000_000;
   localparam int BAUD   = 125_000;
   localparam int DIV    = 8;   // (1_000_000 + 62_500) / 125_000

   localparam logic [7:0] NOP_FRAME [17] = '{
      8'h00, 8'h11, 8'h22, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
      8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       uart_rx = 1'b1;
   logic       uart_tx;
   logic       cmd_byte_req;
   logic [7:0] cmd_byte_data;
   logic       cmd_byte_ack = 1'b0;
   logic       rsp_byte_req = 1'b0;
   logic [7:0] rsp_byte_data = 8'h00;
   logic       rsp_byte_ack;
   logic       rx_overrun;
   logic       rx_frame_err;

   int         n_assert = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   fcr_uart_bridge #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .RX_FIFO_AW(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .uart_rx       (uart_rx),
      .uart_tx       (uart_tx),
      .cmd_byte_req  (cmd_byte_req),
      .cmd_byte_data (cmd_byte_data),
      .cmd_byte_ack  (cmd_byte_ack),
      .rsp_byte_req  (rsp_byte_req),
      .rsp_byte_data (rsp_byte_data),
      .rsp_byte_ack  (rsp_byte_ack),
      .rx_overrun    (rx_overrun),
      .rx_frame_err  (rx_frame_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      cycles(DIV);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         cycles(DIV);
      end
      uart_rx = stop;
      cycles(DIV);
      uart_rx = 1'b1;
   endtask

   task automatic consume(input int n);
      for (int i = 0; i < n; i++) begin
         int t;
         logic [7:0] e;
         t = 0;
         while (!cmd_byte_req && t < 2000) begin
            cycles(1);
            t++;
         end
         chk("req_seen", cmd_byte_req, 1);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
         chk("cmd_data", cmd_byte_data, e);
         cycles(1);
         cmd_byte_ack = 1'b1;
         t = 0;
         while (cmd_byte_req && t < 50) begin
            cycles(1);
            t++;
         end
         chk("req_fall", cmd_byte_req, 0);
         chk("data_hold", cmd_byte_data, e);
         cmd_byte_ack = 1'b0;
         cycles(1);
      end
   endtask

   initial begin
      int lat;
      int rises;
      logic prev;
      logic [9:0] frame_a5;
      logic [7:0] fill [17];

      // Reset values
      cycles(3);
      chk("rst_uart_tx", uart_tx, 1);
      chk("rst_cmd_req", cmd_byte_req, 0);
      chk("rst_cmd_data", cmd_byte_data, 8'h00);
      chk("rst_rsp_ack", rsp_byte_ack, 0);
      chk("rst_overrun", rx_overrun, 0);
      chk("rst_frame_err", rx_frame_err, 0);
      rst_n = 1'b1;
      cycles(3);

      // Single byte, ack to req-fall latency, single req rise
      send_byte(8'h01, 1'b1);
      lat = 0;
      while (!cmd_byte_req && lat < 200) begin
         cycles(1);
         lat++;
      end
      chk("b01_req", cmd_byte_req, 1);
      chk("b01_data", cmd_byte_data, 8'h01);
      cmd_byte_ack = 1'b1;
      lat = 0;
      do begin
         cycles(1);
         lat++;
      end while (cmd_byte_req && lat < 20);
      chk("ack_to_req_fall", lat, 3);
      cmd_byte_ack = 1'b0;
      rises = 0;
      prev = cmd_byte_req;
      for (int i = 0; i < 30; i++) begin
         cycles(1);
         if (cmd_byte_req && !prev) rises++;
         prev = cmd_byte_req;
      end
      chk("b01_req_once", rises, 0);

      // 17-byte NOP frame back to back with a live consumer
      for (int i = 0; i < C_FRAME_BYTES; i++) exp_q.push_back(NOP_FRAME[i]);
      fork
         begin
            for (int i = 0; i < C_FRAME_BYTES; i++) send_byte(NOP_FRAME[i], 1'b1);
         end
         consume(C_FRAME_BYTES);
      join
      chk("nop_queue_empty", exp_q.size(), 0);
      chk("nop_overrun", rx_overrun, 0);
      chk("nop_frame_err", rx_frame_err, 0);

      // Consumer stalls: 17 bytes fit (1 on req + 16 in FIFO), the 18th overruns
      for (int i = 0; i < C_FRAME_BYTES; i++) begin
         fill[i] = 8'h40 + 8'(3 * i);
         exp_q.push_back(fill[i]);
         send_byte(fill[i], 1'b1);
      end
      cycles(4);
      chk("stall_req", cmd_byte_req, 1);
      chk("stall_data", cmd_byte_data, fill[0]);
      chk("stall_no_overrun", rx_overrun, 0);
      send_byte(8'hEE, 1'b1);
      cycles(4);
      chk("stall_overrun", rx_overrun, 1);
      consume(C_FRAME_BYTES);
      cycles(40);
      chk("stall_18th_dropped", cmd_byte_req, 0);
      chk("stall_frame_err", rx_frame_err, 0);

      // Response byte 0xA5 out on uart_tx, second req held off until stop bit ends
      frame_a5 = 10'b1101001010;
      rsp_byte_data = 8'hA5;
      rsp_byte_req = 1'b1;
      lat = 0;
      do begin
         cycles(1);
         lat++;
      end while (!rsp_byte_ack && lat < 20);
      chk("rsp_req_to_ack", lat, 3);
      rsp_byte_req = 1'b0;
      cycles(1 + DIV / 2);
      chk("tx_a5_bit0", uart_tx, frame_a5[0]);
      chk("rsp_ack_fell", rsp_byte_ack, 0);
      rsp_byte_data = 8'h3C;
      rsp_byte_req = 1'b1;
      for (int k = 1; k < 10; k++) begin
         cycles(DIV);
         chk($sformatf("tx_a5_bit%0d", k), uart_tx, frame_a5[k]);
         chk("rsp_ack_held_off", rsp_byte_ack, 0);
      end
      lat = 0;
      while (!rsp_byte_ack && lat < 40) begin
         cycles(1);
         lat++;
      end
      chk("rsp_ack2_seen", rsp_byte_ack, 1);
      chk("rsp_ack2_after_stop", lat >= DIV / 2, 1);
      rsp_byte_req = 1'b0;
      cycles(1 + DIV / 2);
      chk("tx_3c_start", uart_tx, 0);

      // Reset in the middle of the second frame
      rst_n = 1'b0;
      #1;
      chk("midtx_rst_uart_tx", uart_tx, 1);
      chk("midtx_rst_ack", rsp_byte_ack, 0);
      chk("midtx_rst_overrun", rx_overrun, 0);
      cycles(2);
      rst_n = 1'b1;
      cycles(3);
      chk("post_rst_uart_tx", uart_tx, 1);

      // Quarter-bit glitch on an idle line
      uart_rx = 1'b0;
      cycles(DIV / 4);
      uart_rx = 1'b1;
      cycles(40);
      chk("glitch_req", cmd_byte_req, 0);
      chk("glitch_frame_err", rx_frame_err, 0);
      chk("glitch_overrun", rx_overrun, 0);

      // Stop bit sampled low
      send_byte(8'h55, 1'b0);
      cycles(10);
      chk("stoplow_frame_err", rx_frame_err, 1);
      cycles(30);
      chk("stoplow_req", cmd_byte_req, 0);
      chk("stoplow_overrun", rx_overrun, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
